shift_load_ctrl: RTL
====================

SHIFT_LOAD_CTRL -- requirements
Module: shift_load_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: word width of the controlled shift register, legal range 2..32.
REQ-002 Parameter GAP, default 0: idle cycles inserted between consecutive shifted bits, legal range 0..15.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  requester has a word to load.
REQ-006 req_ready  output  1  controller can accept a word.
REQ-007 req_data  input  WIDTH  word to load into the shift register.
REQ-008 sr_shift_en  output  1  drives the shift register's shift enable.
REQ-009 sr_serial_in  output  1  drives the shift register's serial input.
REQ-010 sr_parallel_out  input  WIDTH  readback of the shift register's parallel output.
REQ-011 busy  output  1  a load is in progress.
REQ-012 done  output  1  one-cycle pulse when a load completes.
REQ-013 check_err  output  1  readback mismatch flag (see Configuration).

Function
REQ-014 The FSM shall have exactly four states: IDLE, SHIFT, GAP and DONE.
REQ-015 In IDLE, req_ready=1 and busy=0; in all other states, req_ready=0 and busy=1.
REQ-016 Accept occurs when req_valid=1 and req_ready=1 are sampled on the same edge.
  - On accept: capture req_data into an internal word register, clear the bit counter, enter SHIFT.
REQ-017 In SHIFT, sr_shift_en=1 and sr_serial_in=word[WIDTH-1-bitcnt]. Bits go out MSB first, so after WIDTH shifts sr_parallel_out equals the word.
REQ-018 SHIFT transitions:
  - bitcnt==WIDTH-1 -> DONE.
  - Otherwise, GAP>0 -> GAP; GAP==0 -> stay in SHIFT.
  - bitcnt increments on every SHIFT cycle.
REQ-019 In GAP, sr_shift_en=0. The state lasts exactly GAP cycles, then returns to SHIFT.
REQ-020 In DONE, done=1 for exactly one cycle; next state is IDLE.
REQ-021 sr_shift_en shall be 0 in IDLE, GAP and DONE. sr_serial_in shall be 0 whenever sr_shift_en=0.
REQ-022 Latency with accept at edge T:
  - SHIFT spans cycles T+1 .. T+WIDTH+(WIDTH-1)*GAP.
  - DONE is the following cycle.
  - req_ready returns the cycle after DONE.
REQ-023 req_valid and req_data are ignored while busy=1; no request is queued.
REQ-024 Back-to-back loads shall be possible with exactly one IDLE cycle between DONE and the next SHIFT.
REQ-025 Changes on req_data after accept shall not affect the load in progress.

Reset
REQ-026 Synchronous reset, sampled on the rising edge, from any state: next state IDLE, bitcnt=0, gap counter=0, word register=0.
REQ-027 Output values after reset: req_ready=1, busy=0, done=0, sr_shift_en=0, sr_serial_in=0, check_err=0.
REQ-028 Reset mid-load abandons the load with no done pulse. Bits already shifted stay in the shift register.
REQ-029 reset has priority over a simultaneous accept.

Configuration
REQ-030 Macro SHIFT_LOAD_CTRL_CHECK_EN defined:
  - In DONE, sr_parallel_out is compared against the word register.
  - On mismatch, check_err is set at the end of DONE and stays set until the next accept or reset.
  - On match, check_err stays 0.
REQ-031 Macro SHIFT_LOAD_CTRL_CHECK_EN undefined: check_err is tied to 0 and no comparison logic is present. All other behaviour is identical.

Verification
REQ-032 WIDTH=8, GAP=0, with a shift_register connected. Load 8'hA5 -> sr_shift_en high for 8 consecutive cycles, serial bits 1,0,1,0,0,1,0,1, done in cycle T+9, parallel_out=8'hA5, check_err=0.
REQ-033 GAP=2, load 8'h81 -> sr_shift_en pattern 1,0,0 repeated, with 8 enables over 22 cycles, then done; parallel_out=8'h81.
REQ-034 Back-to-back 8'hFF then 8'h00, with req_valid held high -> second accept exactly one cycle after done, final parallel_out=8'h00; req_data toggled during the load has no effect.
REQ-035 Assert reset at the 4th SHIFT cycle of 8'h3C -> next cycle is IDLE, req_ready=1, no done pulse, sr_shift_en=0; reset plus req_valid on the same edge -> no accept.
REQ-036 SHIFT_LOAD_CTRL_CHECK_EN defined, sr_parallel_out forced to 8'h00 while loading 8'h5A -> check_err=1 after DONE, held until the next accept clears it. With the macro undefined, the same stimulus leaves check_err=0.

Source files
------------

// File: rtl/shift_load_ctrl_if.sv
// Signal bundle between a word requester, the shift_load_ctrl controller and
// the external shift register it drives.
interface shift_load_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic             sr_shift_en;
    logic             sr_serial_in;
    logic [WIDTH-1:0] sr_parallel_out;
    logic             busy;
    logic             done;
    logic             check_err;

    // Environment side: requester plus the shift register readback.
    modport master (
        output req_valid, req_data, sr_parallel_out,
        input  req_ready, sr_shift_en, sr_serial_in, busy, done, check_err
    );

    // Controller side.
    modport slave (
        input  req_valid, req_data, sr_parallel_out,
        output req_ready, sr_shift_en, sr_serial_in, busy, done, check_err
    );
endinterface

// File: rtl/shift_load_ctrl.sv
// Loads a word into an external serial-in shift register, MSB first, with GAP idle
// cycles between bits. Optional readback check: define SHIFT_LOAD_CTRL_CHECK_EN.
module shift_load_ctrl #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    shift_load_ctrl_if.slave  bus
);
    localparam int                     CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [3:0]       GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic [3:0]       gap_cnt_q, gap_cnt_d;

    // NOTE: every signal written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        state_d          = state_q;
        word_d           = word_q;
        bitcnt_d         = bitcnt_q;
        gap_cnt_d        = gap_cnt_q;
        bus.req_ready    = 1'b0;
        bus.busy         = 1'b1;
        bus.sr_shift_en  = 1'b0;
        bus.sr_serial_in = 1'b0;
        bus.done         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.req_valid) begin
                    word_d   = bus.req_data;
                    bitcnt_d = '0;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bus.sr_shift_en  = 1'b1;
                bus.sr_serial_in = word_q[LAST_BIT - bitcnt_q];
                bitcnt_d         = bitcnt_q + 1'b1;
                if (bitcnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                end else if (GAP > 0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_LAST;
                end
            end
            ST_GAP: begin
                // Counter is preloaded with GAP-1, so this state lasts GAP cycles.
                if (gap_cnt_q == '0) begin
                    state_d = ST_SHIFT;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            bitcnt_q  <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            bitcnt_q  <= bitcnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

`ifdef SHIFT_LOAD_CTRL_CHECK_EN
    logic check_err_q, check_err_d;

    // Sticky mismatch flag: raised at the end of DONE, cleared by the next accept.
    always_comb begin
        check_err_d = check_err_q;
        if (state_q == ST_IDLE && bus.req_valid) begin
            check_err_d = 1'b0;
        end
        if (state_q == ST_DONE && bus.sr_parallel_out != word_q) begin
            check_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            check_err_q <= 1'b0;
        end else begin
            check_err_q <= check_err_d;
        end
    end

    assign bus.check_err = check_err_q;
`else
    logic unused_parallel;

    assign unused_parallel = ^bus.sr_parallel_out;
    assign bus.check_err   = 1'b0;
`endif

endmodule
